// File: rtl/fft_pckg.sv
// Shared types and defaults for the FFT input ping-pong buffer.
// Holds the bank ownership enum and the address bit-reversal helper.
package fft_pckg;

    localparam int C_FFT_SIZE_LOG2 = 10;
    localparam int C_SAMPLE_WDT    = 16;

    typedef enum logic [1:0] {
        B_EMPTY     = 2'd0,
        B_FILLING   = 2'd1,
        B_FULL      = 2'd2,
        B_COMPUTING = 2'd3
    } bank_state_t;

    // Reverse the low w bits of v; bits at and above w come back as 0.
    function automatic logic [31:0] bit_reverse(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on storage or read register so it maps onto block RAM.
module fft_sdp_ram #(
    parameter int C_ADDR_WDT = 10,
    parameter int C_DATA_WDT = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [C_ADDR_WDT-1:0] waddr,
    input  logic [C_DATA_WDT-1:0] wdata,
    input  logic                  re,
    input  logic [C_ADDR_WDT-1:0] raddr,
    output logic [C_DATA_WDT-1:0] rdata
);

    logic [C_DATA_WDT-1:0] mem [2**C_ADDR_WDT];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds the last word until the next read strobe
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_in_pingpong_buf.sv
// Ping-pong input sample store between the stream slave and FFT core.
// Define FFT_IN_BITREV_EN to store samples at bit-reversed addresses.
module fft_in_pingpong_buf #(
    parameter int C_FFT_SIZE_LOG2 = fft_pckg::C_FFT_SIZE_LOG2,
    parameter int C_SAMPLE_WDT    = fft_pckg::C_SAMPLE_WDT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_push,
    input  logic [C_FFT_SIZE_LOG2-1:0] wr_addr,
    input  logic [C_SAMPLE_WDT-1:0]    wr_re,
    input  logic [C_SAMPLE_WDT-1:0]    wr_im,
    input  logic                       wr_done,
    output logic                       in_full,
    output logic                       comp_start,
    input  logic                       comp_rd_en,
    input  logic [C_FFT_SIZE_LOG2-1:0] comp_rd_addr,
    output logic [C_SAMPLE_WDT-1:0]    comp_rd_re,
    output logic [C_SAMPLE_WDT-1:0]    comp_rd_im,
    input  logic                       comp_done,
    output logic                       comp_bank,
    output logic                       err_ovf
);

    import fft_pckg::*;

    localparam int DW = 2 * C_SAMPLE_WDT;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic        wr_sel_q;
    logic        wr_sel_d;
    logic        rd_sel_q;
    logic        rd_sel_d;
    logic        ovf_d;
    logic        start_d;
    logic        cbank_d;
    logic        full_d;

    logic                       push_ok;
    logic                       any_comp;
    logic [C_FFT_SIZE_LOG2-1:0] ram_waddr;
    logic [DW-1:0]              ram_wdata;
    logic [1:0]                 ram_we;
    logic [1:0]                 ram_re;
    logic [DW-1:0]              ram_rdata [2];
    logic                       rd_zero;
    logic                       rd_bank;
    logic [DW-1:0]              rd_word;

    assign push_ok = wr_push &&
                     (bank_q[wr_sel_q] == B_EMPTY ||
                      bank_q[wr_sel_q] == B_FILLING);

    assign any_comp = (bank_q[0] == B_COMPUTING) ||
                      (bank_q[1] == B_COMPUTING);

    // Bank ownership: write side, then compute release, then start decision
    always_comb begin
        bank_d   = bank_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        ovf_d    = err_ovf;
        start_d  = 1'b0;
        cbank_d  = comp_bank;
        full_d   = 1'b0;

        if (wr_push) begin
            if (!push_ok) begin
                ovf_d = 1'b1;
            end else if (bank_q[wr_sel_q] == B_EMPTY) begin
                bank_d[wr_sel_q] = B_FILLING;
            end
        end

        // Evaluated on the post-push state so push+done closes the frame
        if (wr_done) begin
            case (bank_d[wr_sel_q])
                B_FILLING: begin
                    bank_d[wr_sel_q] = B_FULL;
                    wr_sel_d         = ~wr_sel_q;
                end
                B_EMPTY: ;
                default: ovf_d = 1'b1;
            endcase
        end

        if (comp_done && bank_q[rd_sel_q] == B_COMPUTING) begin
            bank_d[rd_sel_q] = B_EMPTY;
            rd_sel_d         = ~rd_sel_q;
        end

        // Looking at next state lets a start follow wr_done by one cycle
        if (bank_d[rd_sel_d] == B_FULL &&
            bank_d[0] != B_COMPUTING &&
            bank_d[1] != B_COMPUTING) begin
            bank_d[rd_sel_d] = B_COMPUTING;
            start_d          = 1'b1;
            cbank_d          = rd_sel_d;
        end

        full_d = (bank_d[wr_sel_d] == B_FULL) ||
                 (bank_d[wr_sel_d] == B_COMPUTING);
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]  <= B_EMPTY;
            bank_q[1]  <= B_EMPTY;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            err_ovf    <= 1'b0;
            comp_start <= 1'b0;
            comp_bank  <= 1'b0;
            in_full    <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            err_ovf    <= ovf_d;
            comp_start <= start_d;
            comp_bank  <= cbank_d;
            in_full    <= full_d;
        end
    end

`ifdef FFT_IN_BITREV_EN
    assign ram_waddr = C_FFT_SIZE_LOG2'(
        bit_reverse(32'(wr_addr), C_FFT_SIZE_LOG2));
`else
    assign ram_waddr = wr_addr;
`endif

    assign ram_wdata = {wr_re, wr_im};

    assign ram_we[0] = push_ok && (wr_sel_q == 1'b0);
    assign ram_we[1] = push_ok && (wr_sel_q == 1'b1);
    assign ram_re[0] = comp_rd_en && any_comp && (comp_bank == 1'b0);
    assign ram_re[1] = comp_rd_en && any_comp && (comp_bank == 1'b1);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_sdp_ram #(
            .C_ADDR_WDT(C_FFT_SIZE_LOG2),
            .C_DATA_WDT(DW)
        ) u_ram (
            .clk  (clk),
            .we   (ram_we[g]),
            .waddr(ram_waddr),
            .wdata(ram_wdata),
            .re   (ram_re[g]),
            .raddr(comp_rd_addr),
            .rdata(ram_rdata[g])
        );
    end

    // Read-side tag: which bank answered, or zero when nothing computes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_zero <= 1'b1;
            rd_bank <= 1'b0;
        end else if (comp_rd_en) begin
            rd_zero <= ~any_comp;
            rd_bank <= comp_bank;
        end
    end

    assign rd_word    = rd_zero ? '0 : ram_rdata[rd_bank];
    assign comp_rd_re = rd_word[DW-1:C_SAMPLE_WDT];
    assign comp_rd_im = rd_word[C_SAMPLE_WDT-1:0];

endmodule
